// File: rtl/mul_sched_pkg.sv
// Shared types and sizing helpers for the two-requester multiplier scheduler.
package mul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Default multiplier latency and the matching wait-counter width.
    localparam int MUL_LAT_DFLT = 5;
    localparam int CNT_W_DFLT   = $clog2(MUL_LAT_DFLT) + 1;

    // Counter width for an arbitrary latency; one spare bit keeps MUL_LAT-1 representable.
    function automatic int cnt_width(input int lat);
        return $clog2(lat) + 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-served bit.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic upd,
    input  logic upd_idx,
    output logic gnt_vld,
    output logic gnt
);

    logic last_q;
    logic last_d;

    // Remember which requester was served most recently, updated on the completion strobe.
    always_comb begin
        last_d = last_q;
        if (upd) begin
            last_d = upd_idx;
        end
    end

    // Last-served starts at 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    // Single requester wins outright; on contention the one not served last wins.
    always_comb begin
        gnt_vld = req0 | req1;
        gnt     = 1'b0;
        if (req0 && req1) begin
            gnt = ~last_q;
        end else if (req1) begin
            gnt = 1'b1;
        end
    end

endmodule

// File: rtl/mul_sched.sv
// Scheduler sharing one sequential multiplier between two requesters.
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int W       = 4,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    input  logic             req1,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    output logic             done0,
    output logic [2*W-1:0]   y0,
    output logic             done1,
    output logic [2*W-1:0]   y1,
    output logic             busy,
    output logic             m_ld,
    output logic [W-1:0]     m_a,
    output logic [W-1:0]     m_b,
    input  logic [2*W-1:0]   m_y
);

    localparam int CNT_W = cnt_width(MUL_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

    state_t             state_q, state_d;
    logic               g_q, g_d;
    logic [W-1:0]       opa_q, opa_d;
    logic [W-1:0]       opb_q, opb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]     y0_q, y0_d;
    logic [2*W-1:0]     y1_q, y1_d;

    logic               arb_vld;
    logic               arb_gnt;
    logic               job_done;

    assign job_done = (state_q == DONE);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .upd     (job_done),
        .upd_idx (g_q),
        .gnt_vld (arb_vld),
        .gnt     (arb_gnt)
    );

    // Next-state, operand latching, latency countdown, product capture and decoded outputs.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        busy    = 1'b1;
        m_ld    = 1'b0;
        m_a     = '0;
        m_b     = '0;
        done0   = 1'b0;
        done1   = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (arb_vld) begin
                    g_d     = arb_gnt;
                    opa_d   = arb_gnt ? a1 : a0;
                    opb_d   = arb_gnt ? b1 : b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                m_ld    = 1'b1;
                m_a     = opa_q;
                m_b     = opb_q;
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                // Counter reaching zero means mul has had MUL_LAT cycles since the load.
                if (cnt_q == '0) begin
                    if (g_q) begin
                        y1_d = m_y;
                    end else begin
                        y0_d = m_y;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                done0   = ~g_q;
                done1   = g_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight job without a done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            g_q     <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
        end
    end

    assign y0 = y0_q;
    assign y1 = y1_q;

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched with behavioural multiplier models for two builds.
module tb_mul_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Build A: W=4, MUL_LAT=5
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic       done0, done1, busy, m_ld;
    logic [7:0] y0, y1;
    logic [3:0] m_a, m_b;
    logic [7:0] m_y = '0;

    // Build B: W=8, MUL_LAT=9
    logic        b_req0 = 1'b0, b_req1 = 1'b0;
    logic [7:0]  b_a0 = '0, b_b0 = '0, b_a1 = '0, b_b1 = '0;
    logic        b_done0, b_done1, b_busy, b_m_ld;
    logic [15:0] b_y0, b_y1;
    logic [7:0]  b_m_a, b_m_b;
    logic [15:0] b_m_y = '0;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mul_sched #(.W(4), .MUL_LAT(5)) dut_a (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .done0(done0), .y0(y0), .done1(done1), .y1(y1),
        .busy(busy), .m_ld(m_ld), .m_a(m_a), .m_b(m_b), .m_y(m_y)
    );

    mul_sched #(.W(8), .MUL_LAT(9)) dut_b (
        .clk(clk), .rst(rst),
        .req0(b_req0), .a0(b_a0), .b0(b_b0),
        .req1(b_req1), .a1(b_a1), .b1(b_b1),
        .done0(b_done0), .y0(b_y0), .done1(b_done1), .y1(b_y1),
        .busy(b_busy), .m_ld(b_m_ld), .m_a(b_m_a), .m_b(b_m_b), .m_y(b_m_y)
    );

    // Multiplier models: y shows junk until MUL_LAT-1 edges after the load edge.
    logic [7:0]  prod_a = '0;
    int          cnt_a = 0;
    always @(posedge clk) begin
        if (m_ld) begin
            prod_a <= {4'd0, m_a} * {4'd0, m_b};
            m_y    <= 8'hA5;
            cnt_a  <= 4;
        end else if (cnt_a > 0) begin
            cnt_a <= cnt_a - 1;
            if (cnt_a == 1) m_y <= prod_a;
        end
    end

    logic [15:0] prod_b = '0;
    int          cnt_b = 0;
    always @(posedge clk) begin
        if (b_m_ld) begin
            prod_b <= {8'd0, b_m_a} * {8'd0, b_m_b};
            b_m_y  <= 16'hA5A5;
            cnt_b  <= 8;
        end else if (cnt_b > 0) begin
            cnt_b <= cnt_b - 1;
            if (cnt_b == 1) b_m_y <= prod_b;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Request already driven at this negedge; follow the job to its done pulse.
    task automatic run_job(input bit who, input logic [3:0] la, input logic [3:0] lb,
                           input logic [7:0] exp, input bit zap, input string tag);
        int n;
        bit seen, wrong;
        logic [7:0] oth;
        oth = who ? y0 : y1;
        n = 0; seen = 0; wrong = 0;
        while (!seen && n < 40) begin
            tick(); n++;
            if (n == 1) begin
                chk({tag, "_load"}, {23'd0, m_ld, m_a, m_b}, {23'd0, 1'b1, la, lb});
                if (zap) begin a0 = '0; b0 = '0; a1 = '0; b1 = '0; end
            end
            if ((who ? done0 : done1) === 1'b1) wrong = 1;
            if ((who ? done1 : done0) === 1'b1) seen = 1;
        end
        chk({tag, "_lat"}, n, 7);
        chk({tag, "_y"}, who ? y1 : y0, exp);
        chk({tag, "_oth_y"}, who ? y0 : y1, oth);
        chk({tag, "_oth_done"}, {31'd0, wrong}, 0);
        if (who) req1 = 1'b0; else req0 = 1'b0;
        tick();
        chk({tag, "_idle"}, {30'd0, busy, done0 | done1}, 0);
    endtask

    initial begin
        int n;
        bit seen, who;

        // Reset state
        tick(); tick();
        chk("rst_ctl", {28'd0, busy, m_ld, done0, done1}, 0);
        chk("rst_ops", {24'd0, m_a, m_b}, 0);
        chk("rst_y", {16'd0, y0, y1}, 0);
        rst = 1'b1;

        // Single requester 0, then requester 1
        req0 = 1'b1; a0 = 4'b1101; b0 = 4'b1011;
        run_job(0, 4'b1101, 4'b1011, 8'd143, 0, "t1");
        req1 = 1'b1; a1 = 4'b1001; b1 = 4'b0110;
        run_job(1, 4'b1001, 4'b0110, 8'd54, 0, "t2");

        // Operands cleared right after grant must not affect the product
        y0_clear_check: begin
            req0 = 1'b1; a0 = 4'b1101; b0 = 4'b1011;
            run_job(0, 4'b1101, 4'b1011, 8'd143, 1, "t4");
        end

        // Reset during WAIT, then rerun with request still held
        req0 = 1'b1; a0 = 4'b1111; b0 = 4'b1111;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        chk("t5_rst_ctl", {28'd0, busy, m_ld, done0, done1}, 0);
        chk("t5_rst_y", {16'd0, y0, y1}, 0);
        chk("t5_rst_ops", {24'd0, m_a, m_b}, 0);
        rst = 1'b1;
        run_job(0, 4'b1111, 4'b1111, 8'd225, 0, "t5");

        // Contention from reset, both requests held: alternate 0,1,0,1
        rst = 1'b0; tick(); rst = 1'b1;
        req0 = 1'b1; a0 = 4'b1111; b0 = 4'b1111;
        req1 = 1'b1; a1 = 4'b0011; b1 = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            n = 0; seen = 0; who = 0;
            while (!seen && n < 40) begin
                tick(); n++;
                if (done0 | done1) begin seen = 1; who = done1; end
            end
            chk($sformatf("t3_lat%0d", k), n, (k == 0) ? 7 : 8);
            chk($sformatf("t3_who%0d", k), {31'd0, who}, k % 2);
            chk($sformatf("t3_y%0d", k), {16'd0, y0, y1}, {16'd0, 8'd225, (k == 0) ? 8'd0 : 8'd15});
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();

        // Wide build: 200*150 with MUL_LAT=9
        b_req0 = 1'b1; b_a0 = 8'd200; b_b0 = 8'd150;
        n = 0; seen = 0;
        while (!seen && n < 60) begin
            tick(); n++;
            if (b_done0) seen = 1;
        end
        chk("t6_lat", n, 11);
        chk("t6_y", {16'd0, b_y0}, 30000);
        chk("t6_y1", {16'd0, b_y1}, 0);
        b_req0 = 1'b0;
        tick();
        chk("t6_idle", {31'd0, b_busy}, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_sched.md
Name: mul_sched

Overview:
- Two-requester scheduler for the shared sequential multiplier `mul` (ports clk, rst, ld, a, b, y).
- Arbitrates round-robin between requesters 0 and 1, latches the winner's operands and pulses the multiplier's load.
- Waits a fixed latency, captures the product and returns it to the winner with a one-cycle done pulse.
- Sits between client FSMs and a single `mul` instance, which is instantiated outside this block.

Parameters:
- W, 4, operand width; product width is 2*W.
- MUL_LAT, 5, cycles from the ld cycle until mul.y holds the final product (load + W shift steps); must be >= 1.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous active-low reset.
- req0  input  1  requester 0 request; level, held until done0.
- a0  input  W  requester 0 multiplicand.
- b0  input  W  requester 0 multiplier.
- req1  input  1  requester 1 request; level, held until done1.
- a1  input  W  requester 1 multiplicand.
- b1  input  W  requester 1 multiplier.
- done0  output  1  one-cycle pulse: y0 valid.
- y0  output  2W  requester 0 product, held until next done0.
- done1  output  1  one-cycle pulse: y1 valid.
- y1  output  2W  requester 1 product, held until next done1.
- busy  output  1  high in any state other than IDLE.
- m_ld  output  1  to mul.ld.
- m_a  output  W  to mul.a.
- m_b  output  W  to mul.b.
- m_y  input  2W  from mul.y.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, done0/done1/busy/m_ld=0, m_a/m_b/y0/y1=0, wait counter=0, last-served pointer=1 (so requester 0 wins first contention).
- Any operation in flight on reset is discarded; no done is issued.
- State outputs are registered/decoded from state; m_a/m_b are driven from operand registers and are 0 outside LOAD.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant the requester that is not last-served.
  - On grant: latch grant index g and operands a_g/b_g, go to LOAD.
- LOAD (1 cycle): m_ld=1, m_a/m_b = latched operands; load counter with MUL_LAT-1; go to WAIT.
- WAIT:
  - m_ld=0; decrement counter each cycle.
  - When counter==0, capture m_y into y_g at that edge and go to DONE.
  - WAIT therefore lasts MUL_LAT cycles.
- DONE (1 cycle): done_g=1, other done=0; last-served <= g; go to IDLE.
- Latency: req sampled in IDLE at edge E, LOAD in the cycle after E, done_g high MUL_LAT+1 cycles after LOAD. Request edge to done pulse is MUL_LAT+2 cycles.
- Requester contract: drop req on the edge ending the done cycle. It may re-raise req from the following IDLE cycle.
- The scheduler always spends at least one IDLE cycle between jobs; throughput is 1 job per MUL_LAT+3 cycles.
- Operands are latched at grant; changes to a_g/b_g after grant are ignored.
- req deasserted mid-job: the job still completes and done_g still pulses.
- New req from the non-granted requester during a job: it is held pending and granted in the next IDLE cycle.
- Both requests held continuously: grants alternate 0,1,0,1... with no starvation.
- The non-granted requester's y output never changes.

Decomposition:
- Package mul_sched_pkg:
  - state typedef IDLE/LOAD/WAIT/DONE, 2-bit encoding.
  - localparams for the counter width, clog2(MUL_LAT)+1.
- Sub-module rr_arb2:
  - Combinational grant from req0, req1 and the last-served bit.
  - Registered last-served update on the DONE strobe.
  - Instantiated once.
- Counter and FSM stay in mul_sched; the mul instance is in the parent/bench.

Test Plan:
1. After reset, req0=1, a0=1101, b0=1011 (req1=0) -> m_ld high for one cycle with m_a=1101, m_b=1011; done0 MUL_LAT+2 cycles after req with y0=10001111 (143); done1 never pulses; busy falls the cycle after done0.
2. req1 alone, a1=1001, b1=0110 -> done1 pulses with y1=00110110 (54); y0 keeps its previous value.
3. req0 and req1 raised in the same cycle after reset (0: 1111*1111, 1: 0011*0101) -> requester 0 served first with y0=11100001 (225), then requester 1 with y1=00001111 (15); both requests held continuously -> grants alternate 0,1,0,1.
4. Operands changed to 0000 one cycle after grant -> product uses the latched operands (143 for case 1).
5. rst=0 asserted during WAIT -> the next edge gives state IDLE, all outputs 0, no done pulse; after release with req still high -> the job re-runs and completes correctly.
6. W=8, MUL_LAT=9 build, 200*150 -> y=30000, with done 11 cycles after req.
